// File: rtl/reg_scoreboard_if.sv
// -----------------------------------------------------------------------------
// reg_scoreboard_if
//
// Bundles the ID-issue, squash and WB-retire signals of the register
// scoreboard together with its stall/occupancy outputs.
//
//   master : pipeline side (drives ID/kill/WB info, observes stall)
//   slave  : reg_scoreboard itself
//
//   id_valid_i / id_rs1_addr_i / id_rs2_addr_i / id_rs1_used_i /
//   id_rs2_used_i / id_longlat_i / id_rd_addr_i   instruction trying to issue
//   kill_valid_i / kill_rd_addr_i                 squashed long-latency writer
//   wb_longlat_i / wb_regwrite_i / wb_rd_addr_i   instruction retiring at WB
//   stall_o                                       ID-stage hold request
//   outstanding_o                                 total pending writes
//   stall_cnt_o                                   stall cycle counter, present
//                                                 only with SCOREBOARD_STATS_EN
//
// Optional feature macro: SCOREBOARD_STATS_EN
// -----------------------------------------------------------------------------
interface reg_scoreboard_if #(
    parameter int MAX_OUT = 4
);
    localparam int OUT_W = $clog2(MAX_OUT + 1);

    logic             id_valid_i;
    logic [4:0]       id_rs1_addr_i;
    logic [4:0]       id_rs2_addr_i;
    logic             id_rs1_used_i;
    logic             id_rs2_used_i;
    logic             id_longlat_i;
    logic [4:0]       id_rd_addr_i;
    logic             kill_valid_i;
    logic [4:0]       kill_rd_addr_i;
    logic             wb_longlat_i;
    logic             wb_regwrite_i;
    logic [4:0]       wb_rd_addr_i;
    logic             stall_o;
    logic [OUT_W-1:0] outstanding_o;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0]      stall_cnt_o;
`endif

    modport master (
        output id_valid_i,
        output id_rs1_addr_i,
        output id_rs2_addr_i,
        output id_rs1_used_i,
        output id_rs2_used_i,
        output id_longlat_i,
        output id_rd_addr_i,
        output kill_valid_i,
        output kill_rd_addr_i,
        output wb_longlat_i,
        output wb_regwrite_i,
        output wb_rd_addr_i,
        input  stall_o,
        input  outstanding_o
`ifdef SCOREBOARD_STATS_EN
        ,
        input  stall_cnt_o
`endif
    );

    modport slave (
        input  id_valid_i,
        input  id_rs1_addr_i,
        input  id_rs2_addr_i,
        input  id_rs1_used_i,
        input  id_rs2_used_i,
        input  id_longlat_i,
        input  id_rd_addr_i,
        input  kill_valid_i,
        input  kill_rd_addr_i,
        input  wb_longlat_i,
        input  wb_regwrite_i,
        input  wb_rd_addr_i,
        output stall_o,
        output outstanding_o
`ifdef SCOREBOARD_STATS_EN
        ,
        output stall_cnt_o
`endif
    );

endinterface

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
//
// Producer-side hazard tracker for the 5-stage RISC-V pipeline. Every
// architectural register x1..x31 owns a small pending-write counter that is
// bumped when a long-latency writer (load, multi-cycle mul) issues from ID and
// dropped when that writer retires at WB or is squashed. The ID stage is held
// whenever it would read a still-pending register (a hazard the forwarding
// unit cannot cover) or when it would overflow a counter or the global
// in-flight budget.
//
// Ports:
//   clk_i   clock
//   rst_i   asynchronous, active-low reset; discards all pending state
//   sb      reg_scoreboard_if.slave
//             inputs : ID issue info, kill info, WB retire info
//             outputs: stall_o (combinational, same cycle),
//                      outstanding_o (registered total pending count),
//                      stall_cnt_o (only with SCOREBOARD_STATS_EN)
//
// Parameters:
//   CNT_W    width of each per-register pending counter
//   MAX_OUT  limit on total outstanding long-latency writes
//
// Optional feature macro: SCOREBOARD_STATS_EN adds a saturating 32-bit count
// of stalled cycles.
// -----------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int CNT_W   = 2,
    parameter int MAX_OUT = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    reg_scoreboard_if.slave    sb
);

    localparam int                OUT_W   = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [OUT_W-1:0]  OUT_MAX = OUT_W'(MAX_OUT);

    // Entry 0 exists only so that register addresses index the array
    // directly; it is held at zero and never updated.
    logic [CNT_W-1:0] cnt      [32];
    logic [CNT_W-1:0] cnt_next [32];
    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] outstanding_next;

    logic             issue_ev;
    logic             retire_ev;
    logic             kill_ev;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             src_hit;
    logic             dst_full;
    logic             stall;

    // Retire and kill events are independent of the stall decision; x0 is
    // filtered out here so it never touches any counter.
    always_comb begin
        retire_ev = sb.wb_regwrite_i && sb.wb_longlat_i &&
                    (sb.wb_rd_addr_i != 5'd0);
        kill_ev   = sb.kill_valid_i && (sb.kill_rd_addr_i != 5'd0);
    end

    // Source hazard check. A register retiring this very cycle with only one
    // write in flight is about to be written into the register file, which
    // is write-first, so the reader gets the new value and need not wait.
    always_comb begin
        logic [CNT_W-1:0] rs1_cnt;
        logic [CNT_W-1:0] rs2_cnt;
        logic             rs1_bypass;
        logic             rs2_bypass;

        rs1_cnt    = cnt[sb.id_rs1_addr_i];
        rs2_cnt    = cnt[sb.id_rs2_addr_i];
        rs1_bypass = retire_ev && (sb.wb_rd_addr_i == sb.id_rs1_addr_i) &&
                     (rs1_cnt == CNT_W'(1));
        rs2_bypass = retire_ev && (sb.wb_rd_addr_i == sb.id_rs2_addr_i) &&
                     (rs2_cnt == CNT_W'(1));

        rs1_hit = sb.id_rs1_used_i && (sb.id_rs1_addr_i != 5'd0) &&
                  (rs1_cnt != '0) && !rs1_bypass;
        rs2_hit = sb.id_rs2_used_i && (sb.id_rs2_addr_i != 5'd0) &&
                  (rs2_cnt != '0) && !rs2_bypass;
        src_hit = rs1_hit || rs2_hit;
    end

    // Destination capacity check: a new long-latency writer needs room both
    // in its own counter and in the global in-flight budget. Capacity freed
    // by a same-cycle retire is not borrowed; the issue waits one cycle.
    always_comb begin
        dst_full = sb.id_longlat_i && (sb.id_rd_addr_i != 5'd0) &&
                   ((cnt[sb.id_rd_addr_i] == CNT_MAX) ||
                    (outstanding == OUT_MAX));
        stall    = sb.id_valid_i && (src_hit || dst_full);
        issue_ev = sb.id_valid_i && !stall && sb.id_longlat_i &&
                   (sb.id_rd_addr_i != 5'd0);
    end

    // Per-register net delta (+1 issue, -1 retire, -1 kill) clamped into the
    // counter range, so a retire/kill against an idle register cannot wrap.
    // The global count moves by the sum of the changes actually applied, which
    // keeps it equal to the sum of all per-register counters.
    always_comb begin
        int delta;
        int sum;
        int acc;
        int out_sum;

        acc         = 0;
        cnt_next[0] = '0;
        for (int r = 1; r < 32; r++) begin
            delta = 0;
            if (issue_ev  && (sb.id_rd_addr_i   == 5'(r))) delta = delta + 1;
            if (retire_ev && (sb.wb_rd_addr_i   == 5'(r))) delta = delta - 1;
            if (kill_ev   && (sb.kill_rd_addr_i == 5'(r))) delta = delta - 1;
            sum = int'(cnt[r]) + delta;
            if (sum < 0) begin
                sum = 0;
            end
            if (sum > int'(CNT_MAX)) begin
                sum = int'(CNT_MAX);
            end
            cnt_next[r] = sum[CNT_W-1:0];
            acc         = acc + (sum - int'(cnt[r]));
        end

        out_sum = int'(outstanding) + acc;
        if (out_sum < 0) begin
            out_sum = 0;
        end
        if (out_sum > MAX_OUT) begin
            out_sum = MAX_OUT;
        end
        outstanding_next = out_sum[OUT_W-1:0];
    end

    // Counter state. Reset clears everything immediately, so the stall and
    // occupancy outputs fall without waiting for a clock edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int r = 0; r < 32; r++) begin
                cnt[r] <= '0;
            end
            outstanding <= '0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt[r] <= cnt_next[r];
            end
            outstanding <= outstanding_next;
        end
    end

    assign sb.stall_o       = stall;
    assign sb.outstanding_o = outstanding;

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cnt;

    // Stalled-cycle counter; sticks at all-ones rather than wrapping.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign sb.stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_reg_scoreboard
//
// Self-checking bench for reg_scoreboard. Each stimulus cycle pushes the
// hand-derived stall/outstanding values for that cycle onto a queue; a monitor
// pops and compares them shortly after the inputs settle.
//
// Optional feature macro: SCOREBOARD_STATS_EN (stall counter checks).
// -----------------------------------------------------------------------------
module tb_reg_scoreboard;

    typedef struct {
        string      tag;
        logic       stall;
        logic [2:0] outs;
    } exp_t;

    logic clk;
    logic rst_i;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    exp_t cur;

    reg_scoreboard_if #(.MAX_OUT(4)) sb_if ();

    reg_scoreboard #(
        .CNT_W   (2),
        .MAX_OUT (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .sb    (sb_if.slave)
    );

    // Free-running clock: rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and queue the values the
    // scoreboard must show during that cycle.
    task automatic applyStimulus(input string tag,
                                 input logic v, input logic [4:0] rs1,
                                 input logic u1, input logic [4:0] rs2,
                                 input logic u2, input logic ll,
                                 input logic [4:0] rd, input logic kv,
                                 input logic [4:0] krd, input logic wl,
                                 input logic wr, input logic [4:0] wrd,
                                 input logic es, input logic [2:0] eo);
        exp_t e;
        @(negedge clk);
        sb_if.id_valid_i     = v;
        sb_if.id_rs1_addr_i  = rs1;
        sb_if.id_rs1_used_i  = u1;
        sb_if.id_rs2_addr_i  = rs2;
        sb_if.id_rs2_used_i  = u2;
        sb_if.id_longlat_i   = ll;
        sb_if.id_rd_addr_i   = rd;
        sb_if.kill_valid_i   = kv;
        sb_if.kill_rd_addr_i = krd;
        sb_if.wb_longlat_i   = wl;
        sb_if.wb_regwrite_i  = wr;
        sb_if.wb_rd_addr_i   = wrd;
        e.tag   = tag;
        e.stall = es;
        e.outs  = eo;
        exp_q.push_back(e);
    endtask

    // Monitor: compare queued expectations 2 ns after each falling edge.
    always @(negedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            checkOutput({cur.tag, "_stall"}, 32'(sb_if.stall_o), 32'(cur.stall));
            checkOutput({cur.tag, "_out"}, 32'(sb_if.outstanding_o), 32'(cur.outs));
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_i  = 1'b0;
        sb_if.id_valid_i     = 1'b0;
        sb_if.id_rs1_addr_i  = 5'd0;
        sb_if.id_rs1_used_i  = 1'b0;
        sb_if.id_rs2_addr_i  = 5'd0;
        sb_if.id_rs2_used_i  = 1'b0;
        sb_if.id_longlat_i   = 1'b0;
        sb_if.id_rd_addr_i   = 5'd0;
        sb_if.kill_valid_i   = 1'b0;
        sb_if.kill_rd_addr_i = 5'd0;
        sb_if.wb_longlat_i   = 1'b0;
        sb_if.wb_regwrite_i  = 1'b0;
        sb_if.wb_rd_addr_i   = 5'd0;

        #3;
        checkOutput("reset_stall", 32'(sb_if.stall_o), 32'd0);
        checkOutput("reset_out", 32'(sb_if.outstanding_o), 32'd0);
`ifdef SCOREBOARD_STATS_EN
        checkOutput("reset_stall_cnt", sb_if.stall_cnt_o, 32'd0);
`endif
        @(negedge clk);
        rst_i = 1'b1;

        // Load x5 then dependent add: stalls until the retire cycle bypass.
        $display("[TB] load-use on x5");
        applyStimulus("ld_x5",      1, 1,1, 0,0, 1,5,  0,0, 0,0,0,  0, 3'd0);
        applyStimulus("add_wait1",  1, 5,1, 1,1, 0,6,  0,0, 0,0,0,  1, 3'd1);
        applyStimulus("add_wait2",  1, 5,1, 1,1, 0,6,  0,0, 0,0,0,  1, 3'd1);
        applyStimulus("add_bypass", 1, 5,1, 1,1, 0,6,  0,0, 1,1,5,  0, 3'd1);
        applyStimulus("idle_a",     0, 0,0, 0,0, 0,0,  0,0, 0,0,0,  0, 3'd0);

        // Per-register counter saturation on x7.
        $display("[TB] counter limit on x7");
        applyStimulus("ld_x7_1",    1, 0,0, 0,0, 1,7,  0,0, 0,0,0,  0, 3'd0);
        applyStimulus("ld_x7_2",    1, 0,0, 0,0, 1,7,  0,0, 0,0,0,  0, 3'd1);
        applyStimulus("ld_x7_3",    1, 0,0, 0,0, 1,7,  0,0, 0,0,0,  0, 3'd2);
        applyStimulus("ld_x7_full", 1, 0,0, 0,0, 1,7,  0,0, 0,0,0,  1, 3'd3);
        applyStimulus("ld_x7_ret",  1, 0,0, 0,0, 1,7,  0,0, 1,1,7,  1, 3'd3);
        applyStimulus("ld_x7_go",   1, 0,0, 0,0, 1,7,  0,0, 0,0,0,  0, 3'd2);
        applyStimulus("ret_x7_a",   0, 0,0, 0,0, 0,0,  0,0, 1,1,7,  0, 3'd3);
        applyStimulus("ret_x7_b",   0, 0,0, 0,0, 0,0,  0,0, 1,1,7,  0, 3'd2);
        applyStimulus("ret_x7_c",   0, 0,0, 0,0, 0,0,  0,0, 1,1,7,  0, 3'd1);
        applyStimulus("idle_b",     0, 0,0, 0,0, 0,0,  0,0, 0,0,0,  0, 3'd0);

        // Global budget of four outstanding writes.
        $display("[TB] global budget");
        applyStimulus("ld_x1",      1, 0,0, 0,0, 1,1,  0,0, 0,0,0,  0, 3'd0);
        applyStimulus("ld_x2",      1, 0,0, 0,0, 1,2,  0,0, 0,0,0,  0, 3'd1);
        applyStimulus("ld_x3",      1, 0,0, 0,0, 1,3,  0,0, 0,0,0,  0, 3'd2);
        applyStimulus("ld_x4",      1, 0,0, 0,0, 1,4,  0,0, 0,0,0,  0, 3'd3);
        applyStimulus("ld_x9_full", 1, 0,0, 0,0, 1,9,  0,0, 0,0,0,  1, 3'd4);
        applyStimulus("ld_x9_ret2", 1, 0,0, 0,0, 1,9,  0,0, 1,1,2,  1, 3'd4);
        applyStimulus("ld_x9_go",   1, 0,0, 0,0, 1,9,  0,0, 0,0,0,  0, 3'd3);
        applyStimulus("ret_x1",     0, 0,0, 0,0, 0,0,  0,0, 1,1,1,  0, 3'd4);
        applyStimulus("ret_x3",     0, 0,0, 0,0, 0,0,  0,0, 1,1,3,  0, 3'd3);
        applyStimulus("ret_x4",     0, 0,0, 0,0, 0,0,  0,0, 1,1,4,  0, 3'd2);
        applyStimulus("ret_x9",     0, 0,0, 0,0, 0,0,  0,0, 1,1,9,  0, 3'd1);
        applyStimulus("idle_c",     0, 0,0, 0,0, 0,0,  0,0, 0,0,0,  0, 3'd0);

        // Same-cycle issue and retire on x8 cancel, then a kill clears it.
        $display("[TB] net delta on x8");
        applyStimulus("ld_x8",      1, 0,0, 0,0, 1,8,  0,0, 0,0,0,  0, 3'd0);
        applyStimulus("ld_ret_x8",  1, 0,0, 0,0, 1,8,  0,0, 1,1,8,  0, 3'd1);
        applyStimulus("use_x8",     1, 8,1, 0,0, 0,6,  0,0, 0,0,0,  1, 3'd1);
        applyStimulus("kill_x8",    0, 0,0, 0,0, 0,0,  1,8, 0,0,0,  0, 3'd1);
        applyStimulus("use_x8_ok",  1, 8,1, 0,0, 0,6,  0,0, 0,0,0,  0, 3'd0);

        // x0 and unused sources never stall or count.
        $display("[TB] x0 and unused sources");
        applyStimulus("ld_x0",      1, 0,1, 0,1, 1,0,  0,0, 0,0,0,  0, 3'd0);
        applyStimulus("idle_d",     0, 0,0, 0,0, 0,0,  0,0, 0,0,0,  0, 3'd0);
        applyStimulus("ld_x10",     1, 0,0, 0,0, 1,10, 0,0, 0,0,0,  0, 3'd0);
        applyStimulus("rs2_unused", 1, 0,1, 10,0, 1,0, 0,0, 0,0,0,  0, 3'd1);
        applyStimulus("x0_retkill", 0, 0,0, 0,0, 0,0,  1,0, 1,1,0,  0, 3'd1);
        applyStimulus("rs2_shortwb",1, 0,0, 10,1, 0,6, 0,0, 0,1,10, 1, 3'd1);
        applyStimulus("ret_x10",    0, 0,0, 0,0, 0,0,  0,0, 1,1,10, 0, 3'd1);
        applyStimulus("ret_x20_err",0, 0,0, 0,0, 0,0,  0,0, 1,1,20, 0, 3'd0);
        applyStimulus("idle_e",     0, 0,0, 0,0, 0,0,  0,0, 0,0,0,  0, 3'd0);

        // Asynchronous reset with three writes pending.
        $display("[TB] async reset mid-cycle");
        applyStimulus("ld_x11",     1, 0,0, 0,0, 1,11, 0,0, 0,0,0,  0, 3'd0);
        applyStimulus("ld_x12",     1, 0,0, 0,0, 1,12, 0,0, 0,0,0,  0, 3'd1);
        applyStimulus("ld_x13",     1, 0,0, 0,0, 1,13, 0,0, 0,0,0,  0, 3'd2);
        applyStimulus("use_x11",    1, 11,1, 0,0, 0,6, 0,0, 0,0,0,  1, 3'd3);
        #3;
`ifdef SCOREBOARD_STATS_EN
        checkOutput("stall_cnt_pre", sb_if.stall_cnt_o, 32'd8);
`endif
        rst_i = 1'b0;
        #1;
        checkOutput("async_rst_stall", 32'(sb_if.stall_o), 32'd0);
        checkOutput("async_rst_out", 32'(sb_if.outstanding_o), 32'd0);
`ifdef SCOREBOARD_STATS_EN
        checkOutput("async_rst_stall_cnt", sb_if.stall_cnt_o, 32'd0);
`endif
        @(negedge clk);
        rst_i = 1'b1;
        applyStimulus("post_rst",   1, 11,1, 0,0, 0,6, 0,0, 0,0,0,  0, 3'd0);
        applyStimulus("idle_f",     0, 0,0, 0,0, 0,0,  0,0, 0,0,0,  0, 3'd0);

        repeat (2) @(negedge clk);
        #3;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
